// File: rtl/cam_rr_cache.sv
// Fully associative tag/data CAM cache with round-robin replacement when full,
// update-in-place on tag hit, invalidate-by-tag, registered lookup and hit/miss statistics.
module cam_rr_cache #(
    parameter  int WORDS  = 8,
    parameter  int BITS   = 8,
    parameter  int TAG_SZ = 8,
    parameter  int CNT_W  = 16,
    localparam int AW     = $clog2(WORDS),
    localparam int OW     = $clog2(WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              read,
    input  logic [TAG_SZ-1:0] check_tag,
    input  logic              inval,
    input  logic              write_,
    input  logic [TAG_SZ-1:0] new_tag,
    input  logic [BITS-1:0]   wdata,
    output logic [BITS-1:0]   data,
    output logic              found_it,
    output logic              rd_valid,
    output logic              full,
    output logic [OW-1:0]     count,
    output logic              evicted,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    logic [WORDS-1:0]  val_mem;
    logic [TAG_SZ-1:0] tag_mem  [WORDS];
    logic [BITS-1:0]   data_mem [WORDS];
    logic [AW-1:0]     vptr;

    logic          rd_hit, wr_hit;
    logic [AW-1:0] rd_idx, wr_hit_idx, free_idx, wr_idx;
    logic          do_write, alloc, evict, clear;

    assign full     = (count == OW'(WORDS));
    assign do_write = !write_;

    // Ascending scan lets the highest matching index win; descending scan finds the lowest free slot.
    always_comb begin
        rd_hit     = 1'b0;
        rd_idx     = '0;
        wr_hit     = 1'b0;
        wr_hit_idx = '0;
        free_idx   = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (val_mem[i] && tag_mem[i] == check_tag) begin
                rd_hit = 1'b1;
                rd_idx = AW'(i);
            end
            if (val_mem[i] && tag_mem[i] == new_tag) begin
                wr_hit     = 1'b1;
                wr_hit_idx = AW'(i);
            end
        end
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (!val_mem[i]) free_idx = AW'(i);
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        wr_idx = wr_hit_idx;
        alloc  = 1'b0;
        evict  = 1'b0;
        if (do_write && !wr_hit) begin
            if (!full) begin
                wr_idx = free_idx;
                alloc  = 1'b1;
            end else begin
                wr_idx = vptr;
                evict  = 1'b1;
            end
        end
        // A write landing on the entry being invalidated wins, keeping count consistent.
        clear = inval && rd_hit && !(do_write && wr_idx == rd_idx);
    end

    // NOTE: the arrays are reset explicitly because stale tags/data must read as zero after reset.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            val_mem <= '0;
            for (int i = 0; i < WORDS; i++) begin
                tag_mem[i]  <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            if (clear) val_mem[rd_idx] <= 1'b0;
            if (do_write) begin
                val_mem[wr_idx]  <= 1'b1;
                tag_mem[wr_idx]  <= new_tag;
                data_mem[wr_idx] <= wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            vptr    <= '0;
            count   <= '0;
            evicted <= 1'b0;
        end else begin
            count   <= count + OW'(alloc) - OW'(clear);
            evicted <= evict;
            if (evict) vptr <= (vptr == AW'(WORDS - 1)) ? '0 : vptr + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            data     <= '0;
            found_it <= 1'b0;
            rd_valid <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            rd_valid <= read;
            if (read) begin
                found_it <= rd_hit;
                data     <= rd_hit ? data_mem[rd_idx] : '0;
                if (rd_hit) begin
                    if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
                end else begin
                    if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/cam_rr_cache.md
# cam_rr_cache

Fully associative tag/data CAM cache, next generation of the single-ported allocate-on-free CAM. Adds replacement when full (round-robin victim pointer), update-in-place on tag hit, invalidate-by-tag, a registered lookup port with a valid strobe, an occupancy count, and saturating hit/miss statistics. It sits between the requesting pipeline stage and backing storage as a small lookup cache.

## Interface
- WORDS, 8: number of entries, ≥2; need not be a power of two.
- BITS, 8: data width per entry.
- TAG_SZ, 8: tag width.
- CNT_W, 16: width of hit/miss statistic counters.
- Derived: AW = $clog2(WORDS); OW = $clog2(WORDS+1).

Ports:
- clk  in  1  system clock.
- rst_  in  1  reset, asynchronous, active-low.
- read  in  1  lookup request, active-high.
- check_tag  in  TAG_SZ  lookup tag; also the invalidate tag.
- inval  in  1  invalidate the entry matching check_tag, active-high.
- write_  in  1  write request, active-low.
- new_tag  in  TAG_SZ  tag to write.
- wdata  in  BITS  data to write.
- data  out  BITS  registered lookup data; 0 on miss.
- found_it  out  1  registered lookup hit.
- rd_valid  out  1  one-cycle strobe: data/found_it belong to the previous read.
- full  out  1  all entries valid (combinational from state).
- count  out  OW  number of valid entries (registered).
- evicted  out  1  one-cycle strobe: last write replaced a valid entry of a different tag.
- hit_cnt  out  CNT_W  saturating count of read hits.
- miss_cnt  out  CNT_W  saturating count of read misses.

## Operation
- State: val_mem[WORDS], tag_mem, data_mem, victim pointer vptr (AW bits), count, hit_cnt, miss_cnt.
- Lookup match: entry i matches when val_mem[i] and tag_mem[i]==check_tag. Tags are unique, so at most one entry matches; if more than one does, the highest index wins.
- Write (write_==0). Priority is decided on pre-edge state:
  1. new_tag matches a valid entry: overwrite data in place, no allocation, count unchanged, evicted=0.
  2. Otherwise, if not full: allocate the lowest-index invalid entry, set valid, count+1.
  3. Otherwise (full): replace entry vptr, then vptr = (vptr==WORDS-1) ? 0 : vptr+1, evicted=1, count unchanged.
- vptr advances only on case 3.
- Invalidate (inval=1): clears val_mem of the matching entry. No match: no effect. count decrements only when an entry is actually cleared. Tag and data are left stale.
- Simultaneous write and inval:
  - inval tag == new_tag: the write wins. The entry ends up valid with wdata.
  - Different tags: both take effect. Allocation and fullness use pre-edge state, so a write while full still evicts even if inval frees an entry in the same cycle.
  - count = old + alloc − clear.
- Read statistics: at each read, hit_cnt or miss_cnt increments, saturating at all-ones.
- Reset values: all val_mem=0, tag_mem=0, data_mem=0, vptr=0, count=0, data=0, found_it=0, rd_valid=0, evicted=0, hit_cnt=0, miss_cnt=0. full=0 after reset.
- Reset assertion mid-operation clears everything asynchronously. An in-flight lookup result is lost (rd_valid=0).

## Timing
- Lookup latency is 1 cycle. read sampled at edge N. data/found_it/rd_valid are valid after edge N, for exactly one cycle.
- The lookup reflects state before edge N. A write or invalidate at edge N is not seen by a read sampled at edge N; it is seen by a read at edge N+1.
- When no read is issued, data/found_it hold their last values; rd_valid=0.
- evicted is a pulse after the write edge. count updates at the same edge as the write or invalidate. full follows count combinationally.
- read, write_ and inval may all be asserted in the same cycle; there is no stall or backpressure.

## Test plan
- Reset, then read tag 0x00 → rd_valid=1 next cycle, found_it=0, data=0, miss_cnt=1, count=0, full=0.
- Write tags 0x10..0x17 with data 0xA0..0xA7 (WORDS=8) → count=8, full=1; read 0x13 → data=0xA3, found_it=1, hit_cnt=1.
- Full, then write tag 0x20 with data 0xB0 → entry 0 replaced, evicted=1, vptr=1; read 0x10 misses; read 0x20 → 0xB0. Eight more new-tag writes wrap vptr back to 1.
- Write an existing tag 0x15 with data 0xCC → in-place update, evicted=0, count unchanged, read 0x15 → 0xCC.
- inval 0x14 with a write of new tag 0x30 in the same cycle while full → eviction at vptr, 0x14 cleared, count=7; next write of 0x31 fills the freed lowest-index slot, count=8.
- Read 0x30 in the same cycle as a write of 0x30 → found_it=0 (pre-update state); read one cycle later → hit. Preload hit_cnt near all-ones via repeated hits → it saturates.
